// File: rtl/sweep_pkg.sv
// Shared definitions for the minterm sweep checker.
//   - state_t  : sweep FSM states
//   - NUM_VEC  : number of input vectors in one sweep (all 4-bit combinations)
//   - LAST_IDX : index of the final vector
//   - GOLDEN_F : default golden truth table, F = m(0,1,8,9,10,11,12,14,15)
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int          NUM_VEC  = 16;
    localparam logic [3:0]  LAST_IDX = 4'(NUM_VEC - 1);
    localparam logic [15:0] GOLDEN_F = 16'hDF03;

endpackage

// File: rtl/settle_timer.sv
// Settle interval timer for the sweep checker.
// Loadable down-counter: i_load reloads SETTLE-1, i_en decrements toward zero,
// o_expired is high once the count has reached zero. With SETTLE=N the FSM
// spends exactly N cycles in DRIVE after a load.
// Ports:
//   clk       in  rising-edge clock
//   rst_n     in  asynchronous active-low reset
//   i_load    in  reload the counter with SETTLE-1
//   i_en      in  decrement (ignored when already expired)
//   o_expired out counter is at zero
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [3:0] LOAD_VAL = 4'(SETTLE - 1);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= LOAD_VAL;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_expired = (r_cnt == 4'd0);

endmodule

// File: rtl/minterm_sweep_checker.sv
// Sweep engine for a 4-input combinational logic stage.
// Drives vectors 0..15 on vec_out, holds each for SETTLE cycles, samples f_in,
// compares against EXP_MASK and accumulates the observed truth table.
// Optional build macro: SWEEP_STOP_ON_FAIL_EN -- end the sweep at the first
// mismatch instead of running all 16 vectors.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   level request; accepted in IDLE (and in DONE, see below)
//   vec_out    out  [3:0] {W,X,Y,Z} to the logic stage
//   f_in       in   logic stage output
//   busy       out  high in DRIVE and SAMPLE
//   done       out  one-cycle pulse while in DONE
//   pass       out  no mismatches in the last completed sweep
//   err_count  out  [4:0] mismatch count 0..16
//   captured   out  [15:0] observed F per vector
//   first_fail out  [3:0] index of first mismatch (valid when err_count!=0)
module minterm_sweep_checker
    import sweep_pkg::*;
#(
    parameter logic [15:0] EXP_MASK = GOLDEN_F,
    parameter int          SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  vec_out,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] captured,
    output logic [3:0]  first_fail
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_idx;
    logic [4:0]  r_err;
    logic [15:0] r_cap;
    logic [3:0]  r_ff;
    logic        r_pass;

    logic        w_expired;
    logic        w_tmr_load;
    logic        w_tmr_en;
    logic        w_start_ok;
    logic        w_mis;
    logic        w_last;
    logic [4:0]  w_err_next;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    assign w_mis      = (r_state == SAMPLE) && (f_in != EXP_MASK[r_idx]);
    assign w_err_next = r_err + {4'd0, w_mis};

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign w_last = w_mis || (r_idx == LAST_IDX);
`else
    assign w_last = (r_idx == LAST_IDX);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE also accepts start so that a continuously held start re-arms on
    // the edge right after the done pulse, with no idle gap cycle.
    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next     = DRIVE;
                    w_start_ok = 1'b1;
                    w_tmr_load = 1'b1;
                end
            end
            DRIVE: begin
                if (w_expired) begin
                    w_next = SAMPLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            SAMPLE: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next     = DRIVE;
                    w_tmr_load = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    w_next     = DRIVE;
                    w_start_ok = 1'b1;
                    w_tmr_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Result accumulation. r_idx is not cleared on entering IDLE so that
    // vec_out keeps showing the last driven vector until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= 4'd0;
            r_err  <= 5'd0;
            r_cap  <= 16'd0;
            r_ff   <= 4'd0;
            r_pass <= 1'b0;
        end else if (w_start_ok) begin
            r_idx  <= 4'd0;
            r_err  <= 5'd0;
            r_cap  <= 16'd0;
            r_ff   <= 4'd0;
            r_pass <= 1'b0;
        end else if (r_state == SAMPLE) begin
            r_cap[r_idx] <= f_in;
            r_err        <= w_err_next;
            if (w_mis && (r_err == 5'd0)) begin
                r_ff <= r_idx;
            end
            // pass is taken from the post-update count so a mismatch on the
            // final vector is still reflected while done is high.
            if (w_last) begin
                r_pass <= (w_err_next == 5'd0);
            end else begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    assign vec_out    = r_idx;
    assign busy       = (r_state == DRIVE) || (r_state == SAMPLE);
    assign done       = (r_state == DONE);
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign captured   = r_cap;
    assign first_fail = r_ff;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
module tb_minterm_sweep_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  vec_out;
    logic        f_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [15:0] captured;
    logic [3:0]  first_fail;

    logic [15:0] model_mask;

    int total;
    int bad;

    minterm_sweep_checker #(
        .EXP_MASK (16'hDF03),
        .SETTLE   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec_out    (vec_out),
        .f_in       (f_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .captured   (captured),
        .first_fail (first_fail)
    );

    // Behavioural logic stage: F for the driven vector comes from model_mask.
    assign f_in = model_mask[vec_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] model;
        logic [4:0]  err;
        logic [3:0]  ff;
        logic [15:0] cap;
        logic        pass;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vec"},   32'(vec_out), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_pass"},  32'(pass), 32'd0);
        check({tag, "_err"},   32'(err_count), 32'd0);
        check({tag, "_cap"},   32'(captured), 32'd0);
        check({tag, "_ff"},    32'(first_fail), 32'd0);
    endtask

    // Start a sweep with a one-cycle start pulse (seen at edge 0). Optionally
    // re-pulse start so that it is high at edge pulse_at. Watches 55 edges.
    task automatic run_sweep(input logic [15:0] m, input int pulse_at,
                             output int done_edge, output int n_done);
        model_mask = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("vec_first", 32'(vec_out), 32'd0);
        done_edge = -1;
        n_done = 0;
        for (int n = 1; n <= 55; n++) begin
            @(posedge clk);
            #1;
            if (n == pulse_at - 1) start = 1'b1;
            if (n == pulse_at) start = 1'b0;
            if (done) begin
                n_done++;
                if (done_edge < 0) done_edge = n;
            end
        end
    endtask

    initial begin
        int de;
        int nd;
        int hold_done[4];
        int hold_n;

        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        model_mask = 16'hDF03;

        tbl[0] = '{"correct",   16'hDF03, 5'd0, 4'd0,  16'hDF03, 1'b1};
        tbl[1] = '{"bit5_inv",  16'hDF23, 5'd1, 4'd5,  16'hDF23, 1'b0};
        tbl[2] = '{"tied0",     16'h0000, 5'd9, 4'd0,  16'h0000, 1'b0};
        tbl[3] = '{"tied1",     16'hFFFF, 5'd7, 4'd2,  16'hFFFF, 1'b0};
        tbl[4] = '{"bit0_inv",  16'hDF02, 5'd1, 4'd0,  16'hDF02, 1'b0};
        tbl[5] = '{"bit15_inv", 16'h5F03, 5'd1, 4'd15, 16'h5F03, 1'b0};

        #2;
        check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].model, -10, de, nd);
            check({tbl[i].name, "_done_edge"}, 32'(de), 32'd48);
            check({tbl[i].name, "_done_cnt"},  32'(nd), 32'd1);
            check({tbl[i].name, "_err"},  32'(err_count), 32'(tbl[i].err));
            check({tbl[i].name, "_ff"},   32'(first_fail), 32'(tbl[i].ff));
            check({tbl[i].name, "_cap"},  32'(captured), 32'(tbl[i].cap));
            check({tbl[i].name, "_pass"}, 32'(pass), 32'(tbl[i].pass));
            check({tbl[i].name, "_vec_hold"}, 32'(vec_out), 32'd15);
            check({tbl[i].name, "_busy_idle"}, 32'(busy), 32'd0);
        end

        // start re-pulsed mid-sweep is ignored
        run_sweep(16'hDF03, 20, de, nd);
        check("restart_done_edge", 32'(de), 32'd48);
        check("restart_done_cnt",  32'(nd), 32'd1);
        check("restart_err",  32'(err_count), 32'd0);
        check("restart_cap",  32'(captured), 32'hDF03);
        check("restart_pass", 32'(pass), 32'd1);

        // Reset in the middle of a sweep (with a failing stage, so results are non-zero)
        model_mask = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst_a");
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("midrst_b");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_sweep(16'hDF03, -10, de, nd);
        check("postrst_done_edge", 32'(de), 32'd48);
        check("postrst_err",  32'(err_count), 32'd0);
        check("postrst_cap",  32'(captured), 32'hDF03);
        check("postrst_pass", 32'(pass), 32'd1);

        // start held high for 120 cycles
        model_mask = 16'hDF03;
        start = 1'b1;
        hold_n = 0;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (hold_n < 4) hold_done[hold_n] = n;
                hold_n++;
            end
            if (n == 48) begin
                check("hold_pass_48", 32'(pass), 32'd1);
                check("hold_cap_48",  32'(captured), 32'hDF03);
            end
            if (n == 49) begin
                check("hold_cap_clr", 32'(captured), 32'd0);
                check("hold_pass_clr", 32'(pass), 32'd0);
                check("hold_busy_49", 32'(busy), 32'd1);
                check("hold_done_49", 32'(done), 32'd0);
            end
            if (n == 97) begin
                check("hold_cap_97",  32'(captured), 32'hDF03);
                check("hold_pass_97", 32'(pass), 32'd1);
                check("hold_err_97",  32'(err_count), 32'd0);
            end
        end
        start = 1'b0;
        check("hold_done_cnt", 32'(hold_n), 32'd2);
        if (hold_n >= 2) begin
            check("hold_done0", 32'(hold_done[0]), 32'd48);
            check("hold_done1", 32'(hold_done[1]), 32'd97);
        end
        // let the third sweep finish, bounded
        de = -1;
        for (int n = 121; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done && de < 0) de = n;
        end
        check("hold_third_done", 32'(de), 32'd146);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
